// File: rtl/proc_ctrl_pkg.sv
// ------------------------------------------------------------------
// proc_ctrl_pkg : opcodes, sequencer states and strobe bundle
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package proc_ctrl_pkg;

   localparam logic [4:0] OP_LD   = 5'd0;
   localparam logic [4:0] OP_LDI  = 5'd1;
   localparam logic [4:0] OP_ST   = 5'd2;
   localparam logic [4:0] OP_ADD  = 5'd3;
   localparam logic [4:0] OP_SUB  = 5'd4;
   localparam logic [4:0] OP_AND  = 5'd9;
   localparam logic [4:0] OP_OR   = 5'd10;
   localparam logic [4:0] OP_ADDI = 5'd11;
   localparam logic [4:0] OP_ANDI = 5'd12;
   localparam logic [4:0] OP_ORI  = 5'd13;
   localparam logic [4:0] OP_BR   = 5'd18;
   localparam logic [4:0] OP_NOP  = 5'd26;
   localparam logic [4:0] OP_HALT = 5'd27;

   typedef enum logic [3:0] {
      ST_STOPPED = 4'd0,
      ST_T0      = 4'd1,
      ST_T1      = 4'd2,
      ST_T2      = 4'd3,
      ST_T3      = 4'd4,
      ST_T4      = 4'd5,
      ST_T5      = 4'd6,
      ST_T6      = 4'd7,
      ST_T7      = 4'd8
   } state_e;

   typedef enum logic [2:0] {
      ALU_NONE = 3'd0,
      ALU_ADD  = 3'd1,
      ALU_SUB  = 3'd2,
      ALU_AND  = 3'd3,
      ALU_OR   = 3'd4
   } alu_op_e;

   typedef enum logic [3:0] {
      CLS_ALU     = 4'd0,
      CLS_IMM     = 4'd1,
      CLS_LDI     = 4'd2,
      CLS_LD      = 4'd3,
      CLS_ST      = 4'd4,
      CLS_BR      = 4'd5,
      CLS_NOP     = 4'd6,
      CLS_HALT    = 4'd7,
      CLS_ILLEGAL = 4'd8
   } op_class_e;

   // A single encoded ALU op keeps the four ALU strobes one-hot by construction.
   typedef struct packed {
      logic    pc_out;
      logic    pc_in;
      logic    inc_pc;
      logic    mar_in;
      logic    mdr_in;
      logic    mdr_out;
      logic    read;
      logic    write;
      logic    ir_in;
      logic    y_in;
      logic    z_in;
      logic    zlow_out;
      logic    gra;
      logic    grb;
      logic    grc;
      logic    r_in;
      logic    r_out;
      logic    ba_out;
      logic    c_out;
      logic    con_in;
      alu_op_e alu_op;
   } strobes_t;

   function automatic op_class_e classify(input logic [4:0] op);
      op_class_e cls;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR: cls = CLS_ALU;
         OP_ADDI, OP_ANDI, OP_ORI:      cls = CLS_IMM;
         OP_LDI:                        cls = CLS_LDI;
         OP_LD:                         cls = CLS_LD;
         OP_ST:                         cls = CLS_ST;
         OP_BR:                         cls = CLS_BR;
         OP_NOP:                        cls = CLS_NOP;
         OP_HALT:                       cls = CLS_HALT;
         default:                       cls = CLS_ILLEGAL;
      endcase
      return cls;
   endfunction

   function automatic alu_op_e alu_of(input logic [4:0] op);
      alu_op_e alu;
      case (op)
         OP_ADD, OP_ADDI: alu = ALU_ADD;
         OP_SUB:          alu = ALU_SUB;
         OP_AND, OP_ANDI: alu = ALU_AND;
         OP_OR, OP_ORI:   alu = ALU_OR;
         default:         alu = ALU_NONE;
      endcase
      return alu;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_decode.sv
// ------------------------------------------------------------------
// ctrl_decode : combinational map (state, opcode, con) -> strobes
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module ctrl_decode
   import proc_ctrl_pkg::*;
(
   input  state_e     state_i,
   input  logic [4:0] opcode_i,
   input  logic       con_i,
   output strobes_t   strobes_o
);

   op_class_e cls;
   alu_op_e   alu;

   always_comb begin
      strobes_o = '0;
      cls       = classify(opcode_i);
      alu       = alu_of(opcode_i);
      case (state_i)
         ST_T0: begin
            strobes_o.pc_out = 1'b1;
            strobes_o.mar_in = 1'b1;
            strobes_o.inc_pc = 1'b1;
            strobes_o.z_in   = 1'b1;
         end
         ST_T1: begin
            strobes_o.zlow_out = 1'b1;
            strobes_o.pc_in    = 1'b1;
            strobes_o.read     = 1'b1;
            strobes_o.mdr_in   = 1'b1;
         end
         ST_T2: begin
            strobes_o.mdr_out = 1'b1;
            strobes_o.ir_in   = 1'b1;
         end
         ST_T3: begin
            case (cls)
               CLS_ALU, CLS_IMM: begin
                  strobes_o.grb   = 1'b1;
                  strobes_o.r_out = 1'b1;
                  strobes_o.y_in  = 1'b1;
               end
               CLS_LDI, CLS_LD, CLS_ST: begin
                  strobes_o.grb    = 1'b1;
                  strobes_o.ba_out = 1'b1;
                  strobes_o.y_in   = 1'b1;
               end
               CLS_BR: begin
                  strobes_o.gra    = 1'b1;
                  strobes_o.r_out  = 1'b1;
                  strobes_o.con_in = 1'b1;
               end
               default: ;
            endcase
         end
         ST_T4: begin
            case (cls)
               CLS_ALU: begin
                  strobes_o.grc    = 1'b1;
                  strobes_o.r_out  = 1'b1;
                  strobes_o.alu_op = alu;
                  strobes_o.z_in   = 1'b1;
               end
               CLS_IMM: begin
                  strobes_o.c_out  = 1'b1;
                  strobes_o.alu_op = alu;
                  strobes_o.z_in   = 1'b1;
               end
               CLS_LDI, CLS_LD, CLS_ST: begin
                  strobes_o.c_out  = 1'b1;
                  strobes_o.alu_op = ALU_ADD;
                  strobes_o.z_in   = 1'b1;
               end
               CLS_BR: begin
                  strobes_o.pc_out = 1'b1;
                  strobes_o.y_in   = 1'b1;
               end
               default: ;
            endcase
         end
         ST_T5: begin
            case (cls)
               CLS_ALU, CLS_IMM, CLS_LDI: begin
                  strobes_o.zlow_out = 1'b1;
                  strobes_o.gra      = 1'b1;
                  strobes_o.r_in     = 1'b1;
               end
               CLS_LD, CLS_ST: begin
                  strobes_o.zlow_out = 1'b1;
                  strobes_o.mar_in   = 1'b1;
               end
               CLS_BR: begin
                  strobes_o.c_out  = 1'b1;
                  strobes_o.alu_op = ALU_ADD;
                  strobes_o.z_in   = 1'b1;
               end
               default: ;
            endcase
         end
         ST_T6: begin
            case (cls)
               CLS_LD: begin
                  strobes_o.read   = 1'b1;
                  strobes_o.mdr_in = 1'b1;
               end
               CLS_ST: begin
                  strobes_o.gra    = 1'b1;
                  strobes_o.r_out  = 1'b1;
                  strobes_o.mdr_in = 1'b1;
               end
               CLS_BR: begin
                  strobes_o.zlow_out = con_i;
                  strobes_o.pc_in    = con_i;
               end
               default: ;
            endcase
         end
         ST_T7: begin
            case (cls)
               CLS_LD: begin
                  strobes_o.mdr_out = 1'b1;
                  strobes_o.gra     = 1'b1;
                  strobes_o.r_in    = 1'b1;
               end
               CLS_ST: strobes_o.write = 1'b1;
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
// ------------------------------------------------------------------
// control_unit : hardwired fetch/execute control sequencer
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module control_unit
   import proc_ctrl_pkg::*;
(
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        start_i,
   input  logic [31:0] ir_i,
   input  logic        con_i,
   input  logic        mem_ready_i,
   output logic        PCout_o,
   output logic        PCin_o,
   output logic        IncPC_o,
   output logic        MARin_o,
   output logic        MDRin_o,
   output logic        MDRout_o,
   output logic        Read_o,
   output logic        Write_o,
   output logic        IRin_o,
   output logic        Yin_o,
   output logic        Zin_o,
   output logic        Zlowout_o,
   output logic        Gra_o,
   output logic        Grb_o,
   output logic        Grc_o,
   output logic        Rin_o,
   output logic        Rout_o,
   output logic        BAout_o,
   output logic        Cout_o,
   output logic        CONin_o,
   output logic        ADD_o,
   output logic        SUB_o,
   output logic        AND_o,
   output logic        OR_o,
   output logic        run_o,
   output logic        illegal_o
);

   state_e     state_q, state_d;
   logic       illegal_q, illegal_d;
   logic [4:0] opcode;
   op_class_e  cls;
   strobes_t   strobes;
   logic       unused_ir;

   assign opcode    = ir_i[31:27];
   assign cls       = classify(opcode);
   assign unused_ir = ^ir_i[26:0];

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= ST_STOPPED;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   // Memory steps (T1 fetch, ld T6, st T7) hold their state until mem_ready.
   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q;
      case (state_q)
         ST_STOPPED: begin
            if (start_i) begin
               state_d   = ST_T0;
               illegal_d = 1'b0;
            end
         end
         ST_T0: state_d = ST_T1;
         ST_T1: if (mem_ready_i) state_d = ST_T2;
         ST_T2: state_d = ST_T3;
         ST_T3: begin
            case (cls)
               CLS_NOP:  state_d = ST_T0;
               CLS_HALT: state_d = ST_STOPPED;
               CLS_ILLEGAL: begin
                  state_d   = ST_STOPPED;
                  illegal_d = 1'b1;
               end
               default:  state_d = ST_T4;
            endcase
         end
         ST_T4: state_d = ST_T5;
         ST_T5: begin
            if (cls == CLS_LD || cls == CLS_ST || cls == CLS_BR) state_d = ST_T6;
            else state_d = ST_T0;
         end
         ST_T6: begin
            case (cls)
               CLS_LD:  if (mem_ready_i) state_d = ST_T7;
               CLS_ST:  state_d = ST_T7;
               default: state_d = ST_T0;
            endcase
         end
         ST_T7: if (cls != CLS_ST || mem_ready_i) state_d = ST_T0;
         default: state_d = ST_STOPPED;
      endcase
   end

   ctrl_decode u_decode (
      .state_i   (state_q),
      .opcode_i  (opcode),
      .con_i     (con_i),
      .strobes_o (strobes)
   );

   assign PCout_o   = strobes.pc_out;
   assign PCin_o    = strobes.pc_in;
   assign IncPC_o   = strobes.inc_pc;
   assign MARin_o   = strobes.mar_in;
   assign MDRin_o   = strobes.mdr_in;
   assign MDRout_o  = strobes.mdr_out;
   assign Read_o    = strobes.read;
   assign Write_o   = strobes.write;
   assign IRin_o    = strobes.ir_in;
   assign Yin_o     = strobes.y_in;
   assign Zin_o     = strobes.z_in;
   assign Zlowout_o = strobes.zlow_out;
   assign Gra_o     = strobes.gra;
   assign Grb_o     = strobes.grb;
   assign Grc_o     = strobes.grc;
   assign Rin_o     = strobes.r_in;
   assign Rout_o    = strobes.r_out;
   assign BAout_o   = strobes.ba_out;
   assign Cout_o    = strobes.c_out;
   assign CONin_o   = strobes.con_in;
   assign ADD_o     = (strobes.alu_op == ALU_ADD);
   assign SUB_o     = (strobes.alu_op == ALU_SUB);
   assign AND_o     = (strobes.alu_op == ALU_AND);
   assign OR_o      = (strobes.alu_op == ALU_OR);
   assign run_o     = (state_q != ST_STOPPED);
   assign illegal_o = illegal_q;

endmodule

`default_nettype wire
